// File: rtl/mem_pkg.sv
// Shared defaults and FSM encoding for the memory master.
package mem_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

endpackage

// File: rtl/mem_addr_check.sv
// Byte-address legality check: word alignment and range within the memory.
module mem_addr_check #(
  parameter int ADDR_W = 10
) (
  input  logic [31:0]       byte_addr_i,
  output logic [ADDR_W-1:0] word_idx_o,
  output logic              addr_err_o
);

  // Misaligned addresses or any bit above the word-index range are rejected.
  always_comb begin
    word_idx_o = byte_addr_i[ADDR_W+1:2];
    addr_err_o = (byte_addr_i[1:0] != 2'b00) ||
                 ((byte_addr_i >> (ADDR_W + 2)) != 32'd0);
  end

endmodule

// File: rtl/mem_master.sv
// Request/response master driving a single-port data memory with
// single-word stores and 1-4 word load bursts.
module mem_master
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [1:0]        req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_last,
  output logic              resp_error,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  state_t              state_q, state_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                last_q, last_d;
  logic                err_q, err_d;

  logic [ADDR_W-1:0]   chk_idx;
  logic                chk_err;

  mem_addr_check #(.ADDR_W(ADDR_W)) u_addr_check (
    .byte_addr_i (req_addr),
    .word_idx_o  (chk_idx),
    .addr_err_o  (chk_err)
  );

  // Handshake and memory-side outputs; reset gates the write strobe directly.
  always_comb begin
    req_ready  = (state_q == ST_IDLE) && !reset;
    resp_valid = (state_q == ST_RESP);
    resp_rdata = rdata_q;
    resp_last  = last_q;
    resp_error = err_q;
    mem_wr_en  = (state_q == ST_ACCESS) && write_q && !reset;
    mem_addr   = idx_q;
    mem_din    = wdata_q;
  end

  // Next-state logic: accept, one-cycle memory access, held response beat.
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    last_d  = last_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          idx_d   = chk_idx;
          wdata_d = req_wdata;
          // Stores are always a single beat, whatever req_len says.
          cnt_d   = req_write ? 2'd0 : req_len;
          if (chk_err) begin
            // Illegal address: answer immediately, never touch memory.
            state_d = ST_RESP;
            err_d   = 1'b1;
            last_d  = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = ST_ACCESS;
            err_d   = 1'b0;
          end
        end
      end
      ST_ACCESS: begin
        rdata_d = write_q ? '0 : mem_dout;
        last_d  = (cnt_q == 2'd0);
        err_d   = 1'b0;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          if (last_q) begin
            state_d = ST_IDLE;
          end else begin
            // Index wraps naturally at 2^ADDR_W.
            idx_d   = idx_q + ADDR_W'(1);
            cnt_d   = cnt_q - 2'd1;
            state_d = ST_ACCESS;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and response registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Captured request payload; only meaningful once the FSM leaves IDLE.
  always_ff @(posedge clk) begin
    write_q <= write_d;
    wdata_q <= wdata_d;
  end

endmodule

// File: tb/tb_mem_master.sv
// Randomized self-checking bench for mem_master with a word-array memory.
module tb_mem_master;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [31:0]   req_addr;
  logic [1:0]    req_len;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_ready, resp_last, resp_error;
  logic [DW-1:0] resp_rdata;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  logic [DW-1:0] tb_mem  [0:NW-1];
  logic [DW-1:0] ref_mem [0:NW-1];
  logic          mem_init;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_last  (resp_last),
    .resp_error (resp_error),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  function automatic logic [DW-1:0] init_pat(input int i);
    return DW'(32'hA5A5_0000 ^ (i * 32'h0001_0101));
  endfunction

  // Memory with combinational read and clocked write.
  assign mem_dout = tb_mem[mem_addr];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < NW; i++) tb_mem[i] <= init_pat(i);
    end else if (mem_wr_en) begin
      tb_mem[mem_addr] <= mem_din;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Garbage requests while busy; any acceptance would corrupt memory.
  task automatic noise();
    req_valid = 1'($urandom_range(0, 1));
    req_write = 1'b1;
    req_addr  = {20'd0, 10'($urandom), 2'b00};
    req_len   = 2'($urandom);
    req_wdata = $urandom;
  endtask

  // One request; stall < 0 picks a random 0..3 cycle response back-pressure.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [1:0] len,
                     input logic [DW-1:0] wd, input int stall);
    logic          err;
    int            nb, idx, wr_seen, waited, st;
    logic [DW-1:0] exp_d;
    logic [AW-1:0] exp_a;
    err     = (addr[1:0] != 2'b00) || (addr[31:AW+2] != '0);
    idx     = int'(addr[AW+1:2]);
    nb      = (err || wr) ? 1 : int'(len) + 1;
    wr_seen = 0;
    check_eq("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = len; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int b = 0; b < nb; b++) begin
      exp_a  = AW'((idx + b) % NW);
      waited = 0;
      while (!resp_valid && waited < 8) begin
        if (mem_wr_en) wr_seen++;
        check_eq("access_addr", mem_addr, exp_a);
        if (wr) check_eq("access_din", mem_din, wd);
        noise();
        @(posedge clk); #1;
        waited++;
      end
      check_eq("resp_valid", resp_valid, 1'b1);
      check_eq("beat_latency", waited, (b == 0 && err) ? 0 : 1);
      exp_d = (err || wr) ? '0 : ref_mem[(idx + b) % NW];
      check_eq("resp_rdata", resp_rdata, exp_d);
      check_eq("resp_last", resp_last, b == nb - 1);
      check_eq("resp_error", resp_error, err);
      st = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      for (int s = 0; s < st; s++) begin
        resp_ready = 1'b0;
        noise();
        @(posedge clk); #1;
        if (mem_wr_en) wr_seen++;
        check_eq("hold_valid", resp_valid, 1'b1);
        check_eq("hold_rdata", resp_rdata, exp_d);
        check_eq("hold_last", resp_last, b == nb - 1);
        check_eq("hold_error", resp_error, err);
        check_eq("hold_index", mem_addr, exp_a);
      end
      resp_ready = 1'b1;
      req_valid  = 1'b0;
      @(posedge clk); #1;
      resp_ready = 1'b0;
    end
    check_eq("wr_en_count", wr_seen, (wr && !err) ? 1 : 0);
    check_eq("req_ready_after", req_ready, 1'b1);
    if (wr && !err) ref_mem[idx] = wd;
  endtask

  // Store aborted by reset during its access cycle.
  task automatic store_reset(input logic [31:0] addr, input logic [DW-1:0] wd);
    int idx;
    idx = int'(addr[AW+1:2]);
    check_eq("rst_txn_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_len = 2'd0; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("rst_wr_en", mem_wr_en, 1'b0);
    check_eq("rst_ready_low", req_ready, 1'b0);
    @(posedge clk); #1;
    check_eq("rst_resp_valid", resp_valid, 1'b0);
    check_eq("rst_rdata", resp_rdata, '0);
    check_eq("rst_last", resp_last, 1'b0);
    check_eq("rst_error", resp_error, 1'b0);
    check_eq("rst_index", mem_addr, '0);
    check_eq("rst_wr_en2", mem_wr_en, 1'b0);
    reset = 1'b0;
    #1;
    check_eq("rst_release_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    check_eq("rst_mem_untouched", tb_mem[idx], ref_mem[idx]);
    check_eq("rst_no_resp", resp_valid, 1'b0);
  endtask

  initial begin
    int diffs;
    logic          wr;
    logic [31:0]   a;
    int            sel;
    for (int i = 0; i < NW; i++) ref_mem[i] = init_pat(i);
    reset = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0; req_wdata = '0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mem_init = 1'b0;
    check_eq("init_resp_valid", resp_valid, 1'b0);
    check_eq("init_ready", req_ready, 1'b0);
    check_eq("init_wr_en", mem_wr_en, 1'b0);
    check_eq("init_rdata", resp_rdata, '0);
    check_eq("init_last", resp_last, 1'b0);
    check_eq("init_error", resp_error, 1'b0);
    check_eq("init_index", mem_addr, '0);
    reset = 1'b0;
    #1;
    check_eq("init_ready_release", req_ready, 1'b1);
    @(posedge clk); #1;

    txn(1'b1, 32'h4, 2'd0, 32'hDEADBEEF, 0);
    for (int i = 0; i < 4; i++) txn(1'b1, 32'(i * 4), 2'd0, 32'(32'h10 + i), -1);
    txn(1'b0, 32'h0, 2'd3, '0, -1);
    txn(1'b1, 32'hFFC, 2'd0, 32'hCAFE_0FFC, 0);
    txn(1'b0, 32'hFFC, 2'd1, '0, 0);
    txn(1'b1, 32'h2, 2'd0, 32'h1234_5678, 0);
    txn(1'b0, 32'h1000, 2'd2, '0, 1);
    txn(1'b0, 32'h0, 2'd3, '0, 5);
    store_reset(32'h14, ~ref_mem[5]);

    for (int n = 0; n < 80; n++) begin
      wr  = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 7));
      if (sel == 0)      a = $urandom;
      else if (sel == 1) a = {20'd0, 10'($urandom), 2'($urandom_range(1, 3))};
      else               a = {20'd0, 10'($urandom), 2'b00};
      txn(wr, a, 2'($urandom), $urandom, -1);
    end

    diffs = 0;
    for (int i = 0; i < NW; i++) if (tb_mem[i] !== ref_mem[i]) diffs++;
    check_eq("mem_image", diffs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
